// File: rtl/vlm_mem_responder_if.sv
// VLM request/response bundle between an initiator and a memory responder.
// The master drives the request; the slave answers with hold and read data.
interface vlm_mem_responder_if #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    en;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [WORD_WIDTH-1:0]   din;
    logic [WORD_WIDTH/8-1:0] be;
    logic                    hold;
    logic [WORD_WIDTH-1:0]   dout;

    modport master (
        output en, we, addr, din, be,
        input  hold, dout
    );

    modport slave (
        input  en, we, addr, din, be,
        output hold, dout
    );
endinterface

// File: rtl/vlm_mem_responder.sv
// Byte-writable VLM memory responder with a programmable wait count
// and a dout that only changes on an accepted read.
module vlm_mem_responder #(
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int WAIT_CYCLES = 2
) (
    input logic               clk,
    input logic               rst_n,
    vlm_mem_responder_if.slave bus
);
    localparam int NB = WORD_WIDTH / 8;
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT =
        ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] dout_q, dout_d;
    logic                  hold;
    logic                  acc;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] addr;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    assign addr     = bus.addr;
    assign bus.hold = hold;
    assign bus.dout = dout_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold    = 1'b0;
        acc     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    if (ZERO_WAIT) begin
                        acc = 1'b1;
                    end else begin
                        hold    = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.en) begin
                    // Initiator abort: drop the request without touching memory.
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    hold  = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    acc     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Single port: the read sees the array before this edge's write.
    always_comb begin
        dout_d = dout_q;
        if (acc && !bus.we) begin
            dout_d = mem[addr];
        end
    end

    // A reset edge must never commit a pending write.
    assign wr_en = acc && bus.we && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.be[i]) begin
                    mem[addr][i*8 +: 8] <= bus.din[i*8 +: 8];
                end
            end
        end
    end
endmodule

// File: doc/vlm_mem_responder.md
# vlm_mem_responder

Responder (memory) side of the VLM (variable-latency memory) interface: a word-addressed, byte-writable storage array that accepts one request at a time, stretches each request with `hold` for a programmable number of wait cycles, and obeys the VLM no-change rule on `dout`. It sits behind the cache/memory bus as the backing store. It also serves as the compliant VLM target against which initiators and the cache are verified.

## Interface
- `WORD_WIDTH`, 32, data word width in bits; must be a multiple of 8.
- `DEPTH`, 1024, number of words; power of two, ≥ 2.
- `ADDR_WIDTH`, $clog2(DEPTH), word-address width (derived; do not override).
- `WAIT_CYCLES`, 2, cycles `hold` is asserted per request; 0..15.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  request valid; held with `we/addr/din/be` stable while `hold`=1.
- `we`  in  1  1 = write, 0 = read.
- `addr`  in  ADDR_WIDTH  word address.
- `din`  in  WORD_WIDTH  write data.
- `be`  in  WORD_WIDTH/8  byte enables for writes; ignored on reads.
- `hold`  out  1  responder not ready; request must stay presented.
- `dout`  out  WORD_WIDTH  read data; changes only after an accepted read.

## Operation
- Request accepted in the cycle where `en`=1 and `hold`=0 (the accept cycle).
- FSM states: IDLE, WAIT. 4-bit down-counter `cnt`.
- IDLE:
  - `en`=1, WAIT_CYCLES>0: `hold`=1; load `cnt`=WAIT_CYCLES-1; go to WAIT.
  - `en`=1, WAIT_CYCLES=0: `hold`=0; this is the accept cycle; stay in IDLE.
  - `en`=0: `hold`=0; stay.
- WAIT:
  - `en`=1, `cnt`≠0: `hold`=1; decrement `cnt`.
  - `en`=1, `cnt`=0: `hold`=0; this is the accept cycle; go to IDLE.
  - `en`=0 (initiator abort, protocol violation): `hold`=0; go to IDLE; no access performed.
- `hold` is Mealy: a combinational function of `en` and state. `hold`=0 whenever `en`=0.
- Accepted write: on the accept-cycle edge, for each i with `be[i]`=1, set byte i of mem[`addr`] to byte i of `din`. `be`=0 is a legal no-op write.
- Accepted read: on the accept-cycle edge, `dout` ← mem[`addr`], using contents before any write in that same cycle (single port, so none).
- No-change rule: `dout` holds its value through idle cycles, wait cycles, writes (including writes to the last-read address), and aborted requests.
- Each request costs exactly WAIT_CYCLES+1 cycles of `en`. Back-to-back requests are allowed: the next request may present `en` in the cycle after accept and starts from IDLE.
- Memory contents are not reset; simulation initial value is don't-care.

## Timing
- Reset (`rst_n`=0, async): state=IDLE, `cnt`=0, `dout`=0 immediately. While `en`=0, `hold`=0.
- Reset asserted mid-request: request discarded, no memory write, `dout`=0. After release, any still-present `en` is treated as a new request from IDLE.
- Read latency: `dout` valid in the cycle after the accept cycle, i.e. WAIT_CYCLES+1 cycles after `en` first rises.
- Write visible to a read accepted in any later cycle; a back-to-back read of the same address returns the new data.
- `hold` in the first request cycle depends only on `en` and IDLE, with no register in the path, so initiators see it in the same cycle.
- `cnt` width: 4 bits. WAIT_CYCLES=15 loads 14. No wrap: `cnt` never decrements below 0.

## Test plan
- Reset/idle: assert `rst_n`=0 with `dout` previously 0xDEADBEEF. Expect `dout`=0 asynchronously and `hold`=0. Release with `en`=0: outputs unchanged for 10 cycles.
- Write then read, WAIT_CYCLES=2: write 0x12345678 to addr 5 with `be`=4'hF. Expect `hold`=1,1,0. Then read addr 5: `hold`=1,1,0, and `dout`=0x12345678 in the next cycle, held for 20 idle cycles.
- Byte enables: mem[7]=0xAABBCCDD; write 0x11223344 with `be`=4'b0101. A read returns 0xAA22CC44.
- No-change rule: read addr 3 (0x0000CAFE). Then write 0xFFFFFFFF to addr 3. Expect `dout` to stay 0x0000CAFE until the next accepted read, which returns 0xFFFFFFFF.
- WAIT_CYCLES=0 back-to-back: reads of addr 0,1,2 in consecutive cycles. Expect `hold` always 0 and `dout` = mem[0], mem[1], mem[2] on the following three cycles.
- Abort and mid-request reset, WAIT_CYCLES=3: drop `en` after 1 hold cycle during a write of 0x55 to addr 9. Expect mem[9] unchanged and state back to IDLE. Repeat with `rst_n` pulsed low in the 2nd hold cycle: mem[9] unchanged, `dout`=0.
